// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared sizes and word/address types for the 16x8 dual-port RAM
package ram_pkg;
  localparam int RAM_ADDR_W = 4;
  localparam int RAM_DATA_W = 8;
  localparam int RAM_DEPTH  = 2 ** RAM_ADDR_W;

  typedef logic [RAM_ADDR_W-1:0] ram_addr_t;
  typedef logic [RAM_DATA_W-1:0] ram_data_t;
endpackage

// File: rtl/ram_dp_16x8_if.sv
// rtl/ram_dp_16x8_if.sv - write/read port bundle; master drives accesses, slave is the RAM
interface ram_dp_16x8_if
  import ram_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) ();
  logic              wr_enb;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_enb;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output wr_enb, wr_addr, wr_data, rd_enb, rd_addr,
    input  rd_data
  );

  modport slave (
    input  wr_enb, wr_addr, wr_data, rd_enb, rd_addr,
    output rd_data
  );
endinterface

// File: rtl/ram_mem_array.sv
// rtl/ram_mem_array.sv - reset-clearable register array, one write port, combinational read
module ram_mem_array
  import ram_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Shows pre-edge contents, which gives the top its read-before-write ordering.
  assign rdata = mem[raddr];
endmodule

// File: rtl/ram_dp_16x8.sv
// rtl/ram_dp_16x8.sv - simple dual-port synchronous RAM with registered read data
module ram_dp_16x8
  import ram_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  ram_dp_16x8_if.slave bus
);
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] rd_q;

  ram_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (bus.wr_enb),
    .waddr (bus.wr_addr),
    .wdata (bus.wr_data),
    .raddr (bus.rd_addr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q <= '0;
    end else if (bus.rd_enb) begin
      rd_q <= mem_rdata;
    end
  end

  assign bus.rd_data = rd_q;
endmodule

// File: tb/tb_ram_dp_16x8.sv
// tb/tb_ram_dp_16x8.sv - directed self-checking bench for ram_dp_16x8
module tb_ram_dp_16x8;
  import ram_pkg::*;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  ram_dp_16x8_if #(.ADDR_W(RAM_ADDR_W), .DATA_W(RAM_DATA_W)) bus ();

  ram_dp_16x8 #(.ADDR_W(RAM_ADDR_W), .DATA_W(RAM_DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input ram_addr_t wa, input ram_data_t wd,
                       input logic re, input ram_addr_t ra);
    bus.wr_enb  = we;
    bus.wr_addr = wa;
    bus.wr_data = wd;
    bus.rd_enb  = re;
    bus.rd_addr = ra;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic test_reset();
    ram_addr_t a;
    rst = 1'b1;
    idle();
    #1;
    checks++;
    if (bus.rd_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_initial rd_data got=%h exp=%h", bus.rd_data, 8'h00);
    end
    tick();
    rst = 1'b0;
    tick();
    drive(1'b1, 4'd5, 8'h77, 1'b0, '0);
    tick();
    drive(1'b1, 4'd9, 8'h3C, 1'b1, 4'd5);
    tick();
    idle();
    checks++;
    if (bus.rd_data !== 8'h77) begin
      errors++;
      $display("FAIL reset_prewrite rd_data got=%h exp=%h", bus.rd_data, 8'h77);
    end
    // Mid-cycle, with no clock edge: the clear must be immediate.
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.rd_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_async rd_data got=%h exp=%h", bus.rd_data, 8'h00);
    end
    drive(1'b1, 4'd5, 8'hAB, 1'b1, 4'd9);
    tick();
    checks++;
    if (bus.rd_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_held rd_data got=%h exp=%h", bus.rd_data, 8'h00);
    end
    idle();
    rst = 1'b0;
    for (int i = 0; i < RAM_DEPTH; i++) begin
      a = ram_addr_t'(i);
      drive(1'b0, '0, '0, 1'b1, a);
      tick();
      checks++;
      if (bus.rd_data !== 8'h00) begin
        errors++;
        $display("FAIL reset_sweep addr=%0d got=%h exp=%h", i, bus.rd_data, 8'h00);
      end
    end
    idle();
  endtask

  task automatic test_write_disabled();
    drive(1'b0, 4'd2, 8'hEE, 1'b0, '0);
    tick();
    drive(1'b0, '0, '0, 1'b1, 4'd2);
    tick();
    idle();
    checks++;
    if (bus.rd_data !== 8'h00) begin
      errors++;
      $display("FAIL write_disabled addr=2 got=%h exp=%h", bus.rd_data, 8'h00);
    end
  endtask

  task automatic test_write_read();
    drive(1'b1, 4'd3, 8'hA5, 1'b0, '0);
    tick();
    drive(1'b1, 4'd15, 8'h5A, 1'b0, '0);
    tick();
    drive(1'b0, '0, '0, 1'b1, 4'd3);
    tick();
    checks++;
    if (bus.rd_data !== 8'hA5) begin
      errors++;
      $display("FAIL readback addr=3 got=%h exp=%h", bus.rd_data, 8'hA5);
    end
    drive(1'b0, '0, '0, 1'b1, 4'd15);
    tick();
    idle();
    checks++;
    if (bus.rd_data !== 8'h5A) begin
      errors++;
      $display("FAIL readback addr=15 got=%h exp=%h", bus.rd_data, 8'h5A);
    end
  endtask

  task automatic test_hold();
    drive(1'b0, '0, '0, 1'b1, 4'd3);
    tick();
    checks++;
    if (bus.rd_data !== 8'hA5) begin
      errors++;
      $display("FAIL hold_setup addr=3 got=%h exp=%h", bus.rd_data, 8'hA5);
    end
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 4'd3, 8'hFF, 1'b0, 4'd3);
      tick();
      checks++;
      if (bus.rd_data !== 8'hA5) begin
        errors++;
        $display("FAIL hold cycle=%0d got=%h exp=%h", c, bus.rd_data, 8'hA5);
      end
    end
    drive(1'b0, '0, '0, 1'b1, 4'd3);
    tick();
    idle();
    checks++;
    if (bus.rd_data !== 8'hFF) begin
      errors++;
      $display("FAIL hold_after addr=3 got=%h exp=%h", bus.rd_data, 8'hFF);
    end
  endtask

  task automatic test_collision();
    drive(1'b1, 4'd7, 8'h11, 1'b0, '0);
    tick();
    drive(1'b1, 4'd7, 8'h22, 1'b1, 4'd7);
    tick();
    checks++;
    if (bus.rd_data !== 8'h11) begin
      errors++;
      $display("FAIL collision_old addr=7 got=%h exp=%h", bus.rd_data, 8'h11);
    end
    drive(1'b0, '0, '0, 1'b1, 4'd7);
    tick();
    checks++;
    if (bus.rd_data !== 8'h22) begin
      errors++;
      $display("FAIL collision_new addr=7 got=%h exp=%h", bus.rd_data, 8'h22);
    end
    // Different addresses in the same cycle stay independent.
    drive(1'b1, 4'd8, 8'h33, 1'b1, 4'd15);
    tick();
    checks++;
    if (bus.rd_data !== 8'h5A) begin
      errors++;
      $display("FAIL diff_addr read addr=15 got=%h exp=%h", bus.rd_data, 8'h5A);
    end
    drive(1'b0, '0, '0, 1'b1, 4'd8);
    tick();
    idle();
    checks++;
    if (bus.rd_data !== 8'h33) begin
      errors++;
      $display("FAIL diff_addr write addr=8 got=%h exp=%h", bus.rd_data, 8'h33);
    end
  endtask

  task automatic test_back_to_back();
    ram_addr_t a;
    ram_data_t d;
    for (int i = 0; i < RAM_DEPTH; i++) begin
      a = ram_addr_t'(i);
      d = 8'h10 + ram_data_t'(i);
      drive(1'b1, a, d, 1'b0, '0);
      tick();
    end
    for (int i = 0; i < RAM_DEPTH; i++) begin
      a = ram_addr_t'(i);
      d = 8'h10 + ram_data_t'(i);
      drive(1'b0, '0, '0, 1'b1, a);
      tick();
      checks++;
      if (bus.rd_data !== d) begin
        errors++;
        $display("FAIL sweep addr=%0d got=%h exp=%h", i, bus.rd_data, d);
      end
    end
    idle();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_write_disabled();
    test_write_read();
    test_hold();
    test_collision();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
